// File: rtl/a25_wb_arb_pkg.sv
// rtl/a25_wb_arb_pkg.sv - shared types, defaults and rd-compare helper for the write-back arbiter
//
// Purpose : default widths, the arbiter FSM state encoding and the helper that
//           decides whether a queued load targets the same destination as an
//           incoming execute write.
// Ports   : none (package).
package a25_wb_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 11;

    // Descriptors are zero-extended to this width before comparison so one
    // helper serves any RD_W up to 32 bits.
    localparam int RD_CMP_W = 32;

    typedef enum logic {
        EXEC_PRI = 1'b0,
        LOAD_PRI = 1'b1
    } arb_state_t;

    function automatic logic rd_match(
        input logic                entry_vld,
        input logic [RD_CMP_W-1:0] entry_rd,
        input logic [RD_CMP_W-1:0] cmp_rd
    );
        return entry_vld && (entry_rd == cmp_rd);
    endfunction

endpackage

// File: rtl/a25_wb_load_fifo.sv
// rtl/a25_wb_load_fifo.sv - load-return buffer with associative destination compare
//
// Purpose : synchronous FIFO holding load returns waiting for the register-file
//           write port. Every occupied entry is compared against i_cmp_rd so the
//           arbiter can hold back a younger execute write to the same register.
// Ports   : i_clk, i_rst (sync, active-high)
//           i_push, i_push_data, i_push_rd : enqueue (ignored when full)
//           i_pop                          : dequeue head (ignored when empty)
//           o_head_data, o_head_rd         : oldest entry
//           o_empty, o_full, o_count       : occupancy, from registered count
//           i_cmp_rd, o_any_match          : any occupied entry with rd == i_cmp_rd
module a25_wb_load_fifo
    import a25_wb_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic [RD_W-1:0]          i_push_rd,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head_data,
    output logic [RD_W-1:0]          o_head_rd,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic [RD_W-1:0]          i_cmp_rd,
    output logic                     o_any_match
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [RD_W-1:0]   rd_q   [DEPTH];
    logic [RD_W-1:0]   rd_d   [DEPTH];
    logic              do_push, do_pop;

    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == (AW+1)'(DEPTH));
    assign o_count     = count_q;
    assign o_head_data = data_q[rd_ptr_q];
    assign o_head_rd   = rd_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        data_d   = data_q;
        rd_d     = rd_q;
        count_d  = count_q;

        if (do_push) begin
            data_d[wr_ptr_q] = i_push_data;
            rd_d[wr_ptr_q]   = i_push_rd;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        // Push only targets a free slot, so it never collides with the head.
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + AW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        o_any_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_match(vld_q[i], RD_CMP_W'(rd_q[i]), RD_CMP_W'(i_cmp_rd))) begin
                o_any_match = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by vld_q/count_q.
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
        rd_q   <= rd_d;
    end

endmodule

// File: rtl/a25_wb_arbiter.sv
// rtl/a25_wb_arbiter.sv - register-file write-port arbiter between load returns and execute results
//
// Purpose : load returns are buffered in a small FIFO; execute results are
//           granted combinationally. Loads win when alone, when an execute
//           write targets a queued load's destination (keeps program order),
//           and when the LOAD_PRI state is entered after starvation or a full
//           FIFO. The winner is registered onto the write port.
// Option  : A25_WB_ARB_BYPASS_EN - a load arriving to an empty FIFO that would
//           win anyway skips the FIFO and is written one cycle later.
// Ports   : i_clk, i_rst (sync, active-high)
//           i_load_valid/i_load_data/i_load_rd, o_load_stall : load return side
//           i_exec_valid/i_exec_data/i_exec_rd, o_exec_grant : execute side
//           o_rf_we/o_rf_wdata/o_rf_rd                        : registered write port
module a25_wb_arbiter
    import a25_wb_arb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_W         = RD_W_DEF,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic [RD_W-1:0]   i_load_rd,
    output logic              o_load_stall,
    input  logic              i_exec_valid,
    input  logic [DATA_W-1:0] i_exec_data,
    input  logic [RD_W-1:0]   i_exec_rd,
    output logic              o_exec_grant,
    output logic              o_rf_we,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [RD_W-1:0]   o_rf_rd
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] STARVE_TRIP = SC_W'(STARVE_LIMIT - 1);

    arb_state_t        state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [RD_W-1:0]   rf_rd_q, rf_rd_d;

    logic              fifo_empty, fifo_full, fifo_any_match;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] head_data;
    logic [RD_W-1:0]   head_rd;

    logic exec_req, load_req, head_vld, conflict, lost;
    logic load_win, exec_win, bypass_win, push;

    a25_wb_load_fifo #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_load_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (i_load_data),
        .i_push_rd   (i_load_rd),
        .i_pop       (load_win),
        .o_head_data (head_data),
        .o_head_rd   (head_rd),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full),
        .o_count     (fifo_count),
        .i_cmp_rd    (i_exec_rd),
        .o_any_match (fifo_any_match)
    );

    // Registered count only: a same-cycle dequeue does not release the stall.
    assign o_load_stall = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign o_exec_grant = exec_win;
    assign o_rf_we      = rf_we_q;
    assign o_rf_wdata   = rf_wdata_q;
    assign o_rf_rd      = rf_rd_q;

    always_comb begin
        exec_req   = i_exec_valid && !i_rst;
        load_req   = i_load_valid && !i_rst;
        head_vld   = !fifo_empty && !i_rst;
        conflict   = exec_req && fifo_any_match;
        load_win   = 1'b0;
        exec_win   = 1'b0;
        bypass_win = 1'b0;

        if (head_vld) begin
            if (!exec_req || conflict || (state_q == LOAD_PRI)) begin
                load_win = 1'b1;
            end else begin
                exec_win = 1'b1;
            end
        end else begin
`ifdef A25_WB_ARB_BYPASS_EN
            if (load_req && (!exec_req || (state_q == LOAD_PRI))) begin
                bypass_win = 1'b1;
            end else if (exec_req) begin
                exec_win = 1'b1;
            end
`else
            if (exec_req) begin
                exec_win = 1'b1;
            end
`endif
        end

        push = load_req && !o_load_stall && !bypass_win;
        lost = head_vld && !load_win;

        starve_d = starve_q;
        if (load_win || bypass_win) begin
            starve_d = '0;
        end else if (lost && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SC_W'(1);
        end

        state_d = state_q;
        case (state_q)
            EXEC_PRI: begin
                if ((lost && (starve_q >= STARVE_TRIP)) || fifo_full) begin
                    state_d = LOAD_PRI;
                end
            end
            LOAD_PRI: begin
                if (load_win || bypass_win) begin
                    state_d = EXEC_PRI;
                end
            end
            default: state_d = EXEC_PRI;
        endcase

        rf_we_d    = load_win || exec_win || bypass_win;
        rf_wdata_d = rf_wdata_q;
        rf_rd_d    = rf_rd_q;
        if (load_win) begin
            rf_wdata_d = head_data;
            rf_rd_d    = head_rd;
        end else if (exec_win) begin
            rf_wdata_d = i_exec_data;
            rf_rd_d    = i_exec_rd;
        end else if (bypass_win) begin
            rf_wdata_d = i_load_data;
            rf_rd_d    = i_load_rd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= EXEC_PRI;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
            rf_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
            rf_rd_q    <= rf_rd_d;
        end
    end

endmodule

// File: tb/tb_a25_wb_arbiter.sv
// tb/tb_a25_wb_arbiter.sv - directed self-checking bench for a25_wb_arbiter (default build)
module tb_a25_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_load_valid;
    logic [31:0] i_load_data;
    logic [10:0] i_load_rd;
    logic        o_load_stall;
    logic        i_exec_valid;
    logic [31:0] i_exec_data;
    logic [10:0] i_exec_rd;
    logic        o_exec_grant;
    logic        o_rf_we;
    logic [31:0] o_rf_wdata;
    logic [10:0] o_rf_rd;

    int n_checks = 0;
    int n_pass   = 0;

    a25_wb_arbiter #(
        .DATA_W       (32),
        .RD_W         (11),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .i_load_rd    (i_load_rd),
        .o_load_stall (o_load_stall),
        .i_exec_valid (i_exec_valid),
        .i_exec_data  (i_exec_data),
        .i_exec_rd    (i_exec_rd),
        .o_exec_grant (o_exec_grant),
        .o_rf_we      (o_rf_we),
        .o_rf_wdata   (o_rf_wdata),
        .o_rf_rd      (o_rf_rd)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input logic lv, input logic [31:0] ld, input logic [10:0] lrd,
                          input logic ev, input logic [31:0] ed, input logic [10:0] erd);
        i_load_valid = lv;
        i_load_data  = ld;
        i_load_rd    = lrd;
        i_exec_valid = ev;
        i_exec_data  = ed;
        i_exec_rd    = erd;
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [31:0] d, input logic [10:0] rd);
        check({tag, "_we"},    32'(o_rf_we), 32'(we));
        check({tag, "_wdata"}, o_rf_wdata,   d);
        check({tag, "_rd"},    32'(o_rf_rd), 32'(rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] L1 = 32'h1111_0009;
    localparam logic [31:0] L2 = 32'h2222_000A;
    localparam logic [31:0] FA = 32'hAAAA_0001;
    localparam logic [31:0] FB = 32'hBBBB_0002;
    localparam logic [31:0] FC = 32'hCCCC_0003;

    bit starve_grant [12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    bit full_grant   [12] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0};
    bit full_stall   [12] = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};

    initial begin
        logic [31:0] fd;

        // Reset: grant and enqueue suppressed while i_rst is high.
        i_rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        set_in(1, 32'h5555_5555, 11'h005, 1, 32'hAAAA_AAAA, 11'h003);
        check("rst_grant", 32'(o_exec_grant), 32'd0);
        step();
        i_rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        check_rf("rst_out", 1'b0, 32'h0, 11'h000);
        check("rst_stall", 32'(o_load_stall), 32'd0);
        step();
        check("rst_noenq", 32'(o_rf_we), 32'd0);

        // Lone load: written two cycles after acceptance.
        set_in(1, 32'hDEAD_BEEF, 11'h005, 0, 0, 0);
        check("lone_ld_grant", 32'(o_exec_grant), 32'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        check("lone_ld_n1_we", 32'(o_rf_we), 32'd0);
        step();
        check_rf("lone_ld_n2", 1'b1, 32'hDEAD_BEEF, 11'h005);
        step();
        check_rf("lone_ld_hold", 1'b0, 32'hDEAD_BEEF, 11'h005);

        // Lone exec: same-cycle grant, written next cycle.
        set_in(0, 0, 0, 1, 32'h1234_5678, 11'h003);
        check("lone_ex_grant", 32'(o_exec_grant), 32'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        check_rf("lone_ex_n1", 1'b1, 32'h1234_5678, 11'h003);
        check("lone_ex_idle_grant", 32'(o_exec_grant), 32'd0);
        step();

        // Starvation: exec on rd 1 every cycle, loads at cycles 0 and 6.
        for (int k = 0; k < 12; k++) begin
            set_in((k == 0) || (k == 6), (k == 0) ? L1 : L2, (k == 0) ? 11'h009 : 11'h00A,
                   1, 32'hE000_0000 + 32'(k), 11'h001);
            check($sformatf("starve_grant%0d", k), 32'(o_exec_grant), 32'(starve_grant[k]));
            if (k == 6) begin
                check_rf("starve_ld1", 1'b1, L1, 11'h009);
            end
            step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        check_rf("starve_ld2", 1'b1, L2, 11'h00A);
        step();

        // Full/stall: three back-to-back loads against a saturating exec.
        for (int k = 0; k < 12; k++) begin
            fd = (k == 0) ? FA : (k == 1) ? FB : FC;
            set_in(k < 5, fd, 11'(10 + ((k < 2) ? k : 2)), 1, 32'hF000_0000 + 32'(k), 11'h001);
            check($sformatf("full_grant%0d", k), 32'(o_exec_grant), 32'(full_grant[k]));
            check($sformatf("full_stall%0d", k), 32'(o_load_stall), 32'(full_stall[k]));
            if (k == 4) begin
                check_rf("full_ldA", 1'b1, FA, 11'h00A);
            end
            if (k == 7) begin
                check_rf("full_ldB", 1'b1, FB, 11'h00B);
            end
            step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        check_rf("full_ldC", 1'b1, FC, 11'h00C);
        step();

        // RD conflict: exec to rd 7 held until the queued load to rd 7 is written.
        set_in(1, 32'h7777_0000, 11'h007, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1, 32'h7777_1111, 11'h007);
        check("conf_hold_grant", 32'(o_exec_grant), 32'd0);
        step();
        check_rf("conf_ld", 1'b1, 32'h7777_0000, 11'h007);
        check("conf_release_grant", 32'(o_exec_grant), 32'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        check_rf("conf_ex", 1'b1, 32'h7777_1111, 11'h007);
        step();

        // Reset mid-queue: two loads queued behind exec, then a one-cycle reset.
        set_in(1, 32'h0B0B_0B0B, 11'h00B, 1, 32'hCAFE_0000, 11'h001);
        step();
        set_in(1, 32'h0C0C_0C0C, 11'h00C, 1, 32'hCAFE_0001, 11'h001);
        step();
        i_rst = 1'b1;
        set_in(1, 32'h0D0D_0D0D, 11'h00D, 1, 32'hCAFE_00FF, 11'h001);
        check("mrst_stall_before", 32'(o_load_stall), 32'd1);
        check("mrst_grant", 32'(o_exec_grant), 32'd0);
        step();
        i_rst = 1'b0;
        set_in(0, 0, 0, 1, 32'hCAFE_0002, 11'h002);
        check_rf("mrst_after", 1'b0, 32'h0, 11'h000);
        check("mrst_stall", 32'(o_load_stall), 32'd0);
        check("mrst_ex_grant", 32'(o_exec_grant), 32'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        check_rf("mrst_ex", 1'b1, 32'hCAFE_0002, 11'h002);
        step();
        check("mrst_no_stale", 32'(o_rf_we), 32'd0);
        step();
        check("mrst_no_stale2", 32'(o_rf_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
